// File: rtl/ringbuf_rx_deser.sv
// Purpose: hunts a serial stream for a sync word, deserializes a fixed-length frame into a small output FIFO.
// Latency: 1 clock from the last bit of a word to data_valid; data_out is combinational from FIFO storage.
// Backpressure: data_valid/data_ready handshake; a word completing on a full FIFO without a pop is dropped (sticky overflow).
//
// Ports:
//   clock, reset            - rising-edge clock, asynchronous active-high reset
//   rxda, outstrobe         - serial bit (MSB first) and its per-cycle qualifier
//   data_out, data_valid    - FIFO head word and non-empty flag
//   data_ready              - downstream accepts the head word
//   locked, frame_done      - in-frame status, one-cycle end-of-frame pulse
//   overflow, fifo_level    - sticky drop flag, exact FIFO occupancy
module ringbuf_rx_deser #(
    parameter int                    WORD_WIDTH  = 8,
    parameter int                    FIFO_DEPTH  = 4,
    parameter logic [WORD_WIDTH-1:0] SYNC_WORD   = WORD_WIDTH'(8'hA5),
    parameter int                    FRAME_WORDS = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            rxda,
    input  logic                            outstrobe,
    output logic [WORD_WIDTH-1:0]           data_out,
    output logic                            data_valid,
    input  logic                            data_ready,
    output logic                            locked,
    output logic                            frame_done,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int BW = $clog2(WORD_WIDTH) + 1;

    localparam logic [0:0]    HUNT      = 1'b0;
    localparam logic [0:0]    LOCKED    = 1'b1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(WORD_WIDTH - 1);
    localparam logic [7:0]    LAST_WORD = 8'(FRAME_WORDS);
    localparam logic [LW-1:0] FULL      = LW'(FIFO_DEPTH);

    logic [0:0]            state;
    logic [WORD_WIDTH-1:0] sr;
    logic [WORD_WIDTH-1:0] sr_nxt;
    logic [BW-1:0]         bit_cnt;
    logic [7:0]            word_cnt;
    logic [7:0]            word_cnt_nxt;

    logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [LW-1:0]         level;

    logic word_done;
    logic pop;
    logic full;
    logic push_ok;
    logic drop;

    assign sr_nxt       = {sr[WORD_WIDTH-2:0], rxda};
    assign word_cnt_nxt = word_cnt + 8'd1;
    assign word_done    = outstrobe && (state == LOCKED) && (bit_cnt == LAST_BIT);

    assign pop     = (level != '0) && data_ready;
    assign full    = (level == FULL);
    // A pop on the same edge frees the slot, so a full FIFO still accepts the word.
    assign push_ok = word_done && (!full || pop);
    assign drop    = word_done && full && !pop;

    assign data_valid = (level != '0);
    assign data_out   = data_valid ? mem[rd_ptr] : '0;
    assign locked     = (state == LOCKED);
    assign fifo_level = level;

    // Framing: sync hunt, bit/word counting, end-of-frame handling.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= HUNT;
            sr         <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (outstrobe) begin
                sr <= sr_nxt;
                if (state == HUNT) begin
                    if (sr_nxt == SYNC_WORD) begin
                        state    <= LOCKED;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                    end
                end else if (bit_cnt == LAST_BIT) begin
                    bit_cnt  <= '0;
                    word_cnt <= word_cnt_nxt;
                    // Dropped words still count, so the frame length stays fixed.
                    if (word_cnt_nxt == LAST_WORD) begin
                        state      <= HUNT;
                        sr         <= '0;
                        frame_done <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end
        end
    end

    // FIFO control: pointers, exact occupancy, sticky overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop)      level <= level + LW'(1);
            else if (pop && !push_ok) level <= level - LW'(1);
            if (drop) overflow <= 1'b1;
        end
    end

    // Storage needs no reset: data_out is masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= sr_nxt;
    end

endmodule

// File: tb/tb_ringbuf_rx_deser.sv
module tb_ringbuf_rx_deser;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rxda = 1'b0;
    logic       outstrobe = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready = 1'b0;
    logic       locked;
    logic       frame_done;
    logic       overflow;
    logic [2:0] fifo_level;

    int tests = 0;
    int fails = 0;
    logic [7:0] sb [$];

    ringbuf_rx_deser dut (
        .clock      (clock),
        .reset      (reset),
        .rxda       (rxda),
        .outstrobe  (outstrobe),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .locked     (locked),
        .frame_done (frame_done),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every accepted head word must match the oldest expected word.
    logic [7:0] exp_word;
    always @(negedge clock) begin
        if (!reset && data_valid && data_ready) begin
            if (sb.size() == 0) begin
                check("spurious_valid", {31'b0, data_valid}, 32'd0);
            end else begin
                exp_word = sb.pop_front();
                check("data_word", {24'b0, data_out}, {24'b0, exp_word});
            end
        end
    end

    task automatic send_bit(input logic b, input int gap);
        for (int g = 0; g < gap; g++) begin
            rxda      = 1'($urandom_range(0, 1));
            outstrobe = 1'b0;
            @(posedge clock); #1;
        end
        rxda      = b;
        outstrobe = 1'b1;
        @(posedge clock); #1;
        outstrobe = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input int gmax, input bit expect_push);
        for (int i = 7; i >= 0; i--) send_bit(w[i], $urandom_range(0, gmax));
        if (expect_push) sb.push_back(w);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic drain(input string tag);
        data_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(negedge clock);
        end
        @(negedge clock);
        check(tag, sb.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_out"},   {24'b0, data_out}, 0);
        check({tag, "_data_valid"}, {31'b0, data_valid}, 0);
        check({tag, "_locked"},     {31'b0, locked}, 0);
        check({tag, "_frame_done"}, {31'b0, frame_done}, 0);
        check({tag, "_overflow"},   {31'b0, overflow}, 0);
        check({tag, "_fifo_level"}, {29'b0, fifo_level}, 0);
    endtask

    logic [7:0] w;
    logic [7:0] words [4];

    initial begin
        // Reset state
        reset = 1'b1;
        #12;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;

        // Basic frame with per-word timing
        data_ready = 1'b1;
        w = 8'hA5;
        for (int i = 7; i >= 1; i--) send_bit(w[i], 0);
        @(negedge clock);
        check("basic_locked_pre", {31'b0, locked}, 0);
        send_bit(w[0], 0);
        @(negedge clock);
        check("basic_locked_post", {31'b0, locked}, 1);
        words = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int k = 0; k < 4; k++) begin
            send_word(words[k], 0, 1'b1);
            @(negedge clock);
            check("basic_valid", {31'b0, data_valid}, 1);
            check("basic_head", {24'b0, data_out}, {24'b0, words[k]});
        end
        check("basic_frame_done", {31'b0, frame_done}, 1);
        check("basic_unlock", {31'b0, locked}, 0);
        @(negedge clock);
        check("basic_frame_done_1cyc", {31'b0, frame_done}, 0);
        check("basic_valid_1cyc", {31'b0, data_valid}, 0);
        check("basic_overflow", {31'b0, overflow}, 0);
        check("basic_sb_empty", sb.size(), 0);

        // Misaligned sync after junk bits 101
        do_reset();
        data_ready = 1'b1;
        send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
        w = 8'hA5;
        for (int i = 7; i >= 1; i--) send_bit(w[i], 0);
        @(negedge clock);
        check("mis_locked_pre", {31'b0, locked}, 0);
        send_bit(w[0], 0);
        @(negedge clock);
        check("mis_locked_post", {31'b0, locked}, 1);
        send_word(8'h11, 0, 1'b1);
        send_word(8'h22, 0, 1'b1);
        send_word(8'h33, 0, 1'b1);
        send_word(8'h44, 0, 1'b1);
        drain("mis_drain");
        check("mis_unlock", {31'b0, locked}, 0);

        // Backpressure and overflow
        do_reset();
        data_ready = 1'b0;
        send_word(8'hA5, 0, 1'b0);
        send_word(8'h11, 0, 1'b1);
        send_word(8'h22, 0, 1'b1);
        send_word(8'h33, 0, 1'b1);
        send_word(8'h44, 0, 1'b1);
        @(negedge clock);
        check("ovf_level_full", {29'b0, fifo_level}, 4);
        check("ovf_not_yet", {31'b0, overflow}, 0);
        send_word(8'hA5, 0, 1'b0);
        send_word(8'h55, 0, 1'b0);
        @(negedge clock);
        check("ovf_set", {31'b0, overflow}, 1);
        check("ovf_level_still_full", {29'b0, fifo_level}, 4);
        data_ready = 1'b1;
        send_word(8'h66, 0, 1'b1);
        send_word(8'h77, 0, 1'b1);
        send_word(8'h88, 0, 1'b1);
        drain("ovf_drain");
        check("ovf_sticky", {31'b0, overflow}, 1);

        // Simultaneous push and pop while full
        do_reset();
        data_ready = 1'b0;
        send_word(8'hA5, 0, 1'b0);
        send_word(8'h11, 0, 1'b1);
        send_word(8'h22, 0, 1'b1);
        send_word(8'h33, 0, 1'b1);
        send_word(8'h44, 0, 1'b1);
        send_word(8'hA5, 0, 1'b0);
        w = 8'h55;
        for (int i = 7; i >= 1; i--) send_bit(w[i], 0);
        data_ready = 1'b1;
        send_bit(w[0], 0);
        data_ready = 1'b0;
        sb.push_back(w);
        @(negedge clock);
        check("pp_level", {29'b0, fifo_level}, 4);
        check("pp_no_overflow", {31'b0, overflow}, 0);
        check("pp_head", {24'b0, data_out}, 32'h22);
        drain("pp_drain1");
        send_word(8'h66, 0, 1'b1);
        send_word(8'h77, 0, 1'b1);
        send_word(8'h88, 0, 1'b1);
        drain("pp_drain2");
        check("pp_overflow_end", {31'b0, overflow}, 0);

        // Strobe gaps with random data on idle cycles
        do_reset();
        data_ready = 1'b1;
        send_word(8'hA5, 5, 1'b0);
        send_word(8'hC3, 5, 1'b1);
        send_word(8'h3C, 5, 1'b1);
        send_word(8'h0F, 5, 1'b1);
        send_word(8'hF0, 5, 1'b1);
        drain("gap_drain");
        check("gap_unlock", {31'b0, locked}, 0);

        // Asynchronous reset mid-frame
        do_reset();
        data_ready = 1'b0;
        send_word(8'hA5, 0, 1'b0);
        send_word(8'h11, 0, 1'b0);
        w = 8'h22;
        for (int i = 7; i >= 4; i--) send_bit(w[i], 0);
        @(negedge clock);
        check("mid_level_before", {29'b0, fifo_level}, 1);
        check("mid_locked_before", {31'b0, locked}, 1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        data_ready = 1'b1;
        // Data words without a sync must not be delivered.
        send_word(8'h33, 0, 1'b0);
        send_word(8'h44, 0, 1'b0);
        @(negedge clock);
        check("mid_no_lock", {31'b0, locked}, 0);
        check("mid_no_valid", {31'b0, data_valid}, 0);
        send_word(8'hA5, 0, 1'b0);
        send_word(8'h12, 0, 1'b1);
        send_word(8'h34, 0, 1'b1);
        send_word(8'h56, 0, 1'b1);
        send_word(8'h78, 0, 1'b1);
        drain("mid_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
